// File: rtl/div_pkg.sv
// Shared types for the divider dispatch block: FSM state, queued request entry,
// captured result, and a conditional two's-complement helper.
package div_pkg;

  localparam int unsigned DIV_N     = 16;
  localparam int unsigned DIV_TAG_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} div_state_t;

  typedef struct packed {
    logic [DIV_N-1:0]     dividend;
    logic [DIV_N-1:0]     divisor;
    logic [DIV_TAG_W-1:0] tag;
    logic                 is_signed;
  } div_entry_t;

  typedef struct packed {
    logic [DIV_N-1:0]     q;
    logic [DIV_N-1:0]     r;
    logic [DIV_TAG_W-1:0] tag;
    logic                 exc;
  } div_result_t;

  function automatic logic [DIV_N-1:0] negate_if(input logic neg, input logic [DIV_N-1:0] v);
    return neg ? ('0 - v) : v;
  endfunction

endpackage

// File: rtl/div_fifo.sv
// Request FIFO for the divider dispatch: pointer-plus-count, DEPTH a power of two,
// head entry visible combinationally. Pushes into a full FIFO are dropped.
module div_fifo
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  div_entry_t din,
  output div_entry_t head,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  div_entry_t        mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/div_dispatch.sv
// Operand buffer and issue controller in front of the iterative divider.
// Optional signed support is compiled in with `define DIV_SIGNED_EN.
module div_dispatch
  import div_pkg::*;
#(
  parameter int unsigned N     = DIV_N,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_dividend,
  input  logic [N-1:0]     in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_signed,
  output logic             div_req,
  output logic [N-1:0]     div_dividend,
  output logic [N-1:0]     div_divisor,
  input  logic             div_ready,
  input  logic [N-1:0]     div_q,
  input  logic [N-1:0]     div_r,
  input  logic             div_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_q,
  output logic [N-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exc,
  output logic             busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  div_state_t          state;
  div_entry_t          din;
  div_entry_t          head;
  logic [AW:0]         count;
  logic [AW:0]         count_nx;
  logic                push_fire;
  logic                pop_fire;
  logic                busy_nx;
  logic [DIV_N-1:0]    mag_dividend;
  logic [DIV_N-1:0]    mag_divisor;
  logic [DIV_N-1:0]    cur_dividend;
  logic [DIV_TAG_W-1:0] cur_tag;
  div_result_t         res;
  div_result_t         fin;

  assign in_ready  = (count != FULL_CNT);
  assign push_fire = in_valid && in_ready;
  assign pop_fire  = (state == IDLE) && (count != '0);

  always_comb begin
    din           = '0;
    din.dividend  = in_dividend;
    din.divisor   = in_divisor;
    din.tag       = in_tag;
    din.is_signed = in_signed;
  end

  div_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire),
    .pop   (pop_fire),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // busy is registered, so it is computed from the occupancy and state that
  // will hold after this edge.
  always_comb begin
    count_nx = count;
    if (push_fire && !pop_fire)      count_nx = count + 1'b1;
    else if (!push_fire && pop_fire) count_nx = count - 1'b1;
    if (state == IDLE) busy_nx = (count_nx != '0) || pop_fire;
    else               busy_nx = (count_nx != '0) || !((state == RESP) && out_ready);
  end

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;
  always_comb begin
    a_neg        = head.is_signed && head.dividend[DIV_N-1];
    b_neg        = head.is_signed && head.divisor[DIV_N-1];
    mag_dividend = negate_if(a_neg, head.dividend);
    mag_divisor  = negate_if(b_neg, head.divisor);
  end
`else
  logic unused_sign;
  assign unused_sign  = head.is_signed;
  assign mag_dividend = head.dividend;
  assign mag_divisor  = head.divisor;
`endif

  always_comb begin
    fin     = '0;
    fin.tag = cur_tag;
    if (div_exc) begin
      fin.exc = 1'b1;
      fin.q   = '1;
      fin.r   = cur_dividend;
    end else begin
`ifdef DIV_SIGNED_EN
      fin.q = negate_if(neg_q, div_q);
      fin.r = negate_if(neg_r, div_r);
`else
      fin.q = div_q;
      fin.r = div_r;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_req      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      cur_dividend <= '0;
      cur_tag      <= '0;
      res          <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
`endif
    end else begin
      busy <= busy_nx;
      case (state)
        IDLE: begin
          if (pop_fire) begin
            div_dividend <= mag_dividend;
            div_divisor  <= mag_divisor;
            cur_dividend <= head.dividend;
            cur_tag      <= head.tag;
`ifdef DIV_SIGNED_EN
            neg_q        <= a_neg ^ b_neg;
            neg_r        <= a_neg;
`endif
            div_req      <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          div_req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (div_ready) begin
            res       <= fin;
            out_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_q   = res.q;
  assign out_r   = res.r;
  assign out_tag = res.tag;
  assign out_exc = res.exc;

endmodule

// File: tb/tb_div_dispatch.sv
// Directed self-checking bench for div_dispatch; the bench models the divider.
`timescale 1ns/1ps
module tb_div_dispatch;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_dividend;
  logic [N-1:0]     in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             in_signed;
  logic             div_req;
  logic [N-1:0]     div_dividend;
  logic [N-1:0]     div_divisor;
  logic             div_ready;
  logic [N-1:0]     div_q;
  logic [N-1:0]     div_r;
  logic             div_exc;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_q;
  logic [N-1:0]     out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_exc;
  logic             busy;

  int total = 0;
  int bad   = 0;

  int       div_lat      = 3;
  bit       auto_div     = 1'b0;
  logic     manual_ready = 1'b0;
  logic [15:0] manual_q  = '0;
  logic [15:0] manual_r  = '0;
  int       req_cnt      = 0;

  always #5 clk = ~clk;

  div_dispatch #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .in_tag       (in_tag),
    .in_signed    (in_signed),
    .div_req      (div_req),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ready    (div_ready),
    .div_q        (div_q),
    .div_r        (div_r),
    .div_exc      (div_exc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_q        (out_q),
    .out_r        (out_r),
    .out_tag      (out_tag),
    .out_exc      (out_exc),
    .busy         (busy)
  );

  // Divider model: acts 1ns after the falling edge so stimulus set on that edge is seen.
  initial begin : divider_model
    logic [15:0] a;
    logic [15:0] b;
    div_ready = 1'b0;
    div_q     = '0;
    div_r     = '0;
    div_exc   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      div_ready = 1'b0;
      div_exc   = 1'b0;
      if (!auto_div) begin
        div_ready = manual_ready;
        div_q     = manual_q;
        div_r     = manual_r;
      end else if (div_req) begin
        a = div_dividend;
        b = div_divisor;
        repeat (div_lat) @(negedge clk);
        #1;
        div_ready = 1'b1;
        div_exc   = (b == 16'd0);
        div_q     = (b == 16'd0) ? 16'h1234 : a / b;
        div_r     = (b == 16'd0) ? 16'h5678 : a % b;
      end
    end
  end

  initial begin : req_counter
    forever begin
      @(posedge clk);
      if (div_req) req_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t, input logic s);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    in_signed   = s;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0; in_signed = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (div_req !== 1'b0) begin bad++; $display("FAIL reset_div_req got=%0b exp=0", div_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if ({out_q, out_r, out_exc} !== 33'd0) begin bad++; $display("FAIL reset_outputs got=%0h exp=0", {out_q, out_r, out_exc}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    bit got;
    int r0;
    auto_div = 1'b1; div_lat = 3;
    r0 = req_cnt;
    push(16'd100, 16'd7, 4'd3, 1'b0);
    total++; if (div_req !== 1'b0) begin bad++; $display("FAIL uns_req_early got=%0b exp=0", div_req); end
    @(negedge clk);
    total++; if (div_req !== 1'b1) begin bad++; $display("FAIL uns_req_t2 got=%0b exp=1", div_req); end
    total++; if (div_dividend !== 16'd100 || div_divisor !== 16'd7) begin bad++; $display("FAIL uns_operands got=%0d/%0d exp=100/7", div_dividend, div_divisor); end
    wait_valid(100, got);
    total++; if (!got) begin bad++; $display("FAIL uns_timeout got=0 exp=1"); end
    total++; if (out_q !== 16'd14) begin bad++; $display("FAIL uns_q got=%0d exp=14", out_q); end
    total++; if (out_r !== 16'd2) begin bad++; $display("FAIL uns_r got=%0d exp=2", out_r); end
    total++; if (out_tag !== 4'd3 || out_exc !== 1'b0) begin bad++; $display("FAIL uns_tag_exc got=%0d/%0b exp=3/0", out_tag, out_exc); end
    total++; if (req_cnt - r0 != 1) begin bad++; $display("FAIL uns_req_cycles got=%0d exp=1", req_cnt - r0); end
    accept();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL uns_after_accept got=%0b%0b exp=00", out_valid, busy); end
  endtask

  task automatic test_div_zero();
    bit got;
    auto_div = 1'b1; div_lat = 2;
    push(16'd50, 16'd0, 4'd5, 1'b0);
    wait_valid(100, got);
    total++; if (!got) begin bad++; $display("FAIL dz_timeout got=0 exp=1"); end
    total++; if (out_q !== 16'hFFFF) begin bad++; $display("FAIL dz_q got=%0h exp=ffff", out_q); end
    total++; if (out_r !== 16'd50) begin bad++; $display("FAIL dz_r got=%0d exp=50", out_r); end
    total++; if (out_exc !== 1'b1 || out_tag !== 4'd5) begin bad++; $display("FAIL dz_exc_tag got=%0b/%0d exp=1/5", out_exc, out_tag); end
    accept();
  endtask

  task automatic test_back_to_back();
    bit got;
    bit seen;
    logic [15:0] q_exp [5] = '{16'd6, 16'd7, 16'd7, 16'd7, 16'd8};
    logic [15:0] r_exp [5] = '{16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    auto_div = 1'b1; div_lat = 6;
    for (int k = 0; k < 5; k++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_%0d got=%0b exp=1", k, in_ready); end
      push(16'd20 + 16'(k), 16'd3, 4'(k), 1'b0);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0b exp=0", in_ready); end
    push(16'd99, 16'd3, 4'd9, 1'b0);
    wait_valid(100, got);
    total++; if (!got) begin bad++; $display("FAIL b2b_first_timeout got=0 exp=1"); end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_q !== 16'd6) begin bad++; $display("FAIL b2b_hold got=%0b/%0d/%0d exp=1/0/6", out_valid, out_tag, out_q); end
    for (int k = 0; k < 5; k++) begin
      wait_valid(100, got);
      total++; if (!got) begin bad++; $display("FAIL b2b_timeout_%0d got=0 exp=1", k); end
      total++; if (out_tag !== 4'(k)) begin bad++; $display("FAIL b2b_tag_%0d got=%0d exp=%0d", k, out_tag, k); end
      total++; if (out_q !== q_exp[k] || out_r !== r_exp[k]) begin bad++; $display("FAIL b2b_qr_%0d got=%0d/%0d exp=%0d/%0d", k, out_q, out_r, q_exp[k], r_exp[k]); end
      accept();
      if (k < 4) begin
        total++; if (div_req !== 1'b0) begin bad++; $display("FAIL b2b_req_h1_%0d got=%0b exp=0", k, div_req); end
        @(negedge clk);
        total++; if (div_req !== 1'b1) begin bad++; $display("FAIL b2b_req_h2_%0d got=%0b exp=1", k, div_req); end
      end
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL b2b_rejected_push got=%0b exp=0", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_signed();
    bit got;
    auto_div = 1'b1; div_lat = 2;
`ifdef DIV_SIGNED_EN
    push(16'hFFF9, 16'd2, 4'd1, 1'b1);
    wait_valid(100, got);
    total++; if (!got || out_q !== 16'hFFFD || out_r !== 16'hFFFF || out_exc !== 1'b0) begin bad++; $display("FAIL sgn_m7_2 got=%0h/%0h/%0b exp=fffd/ffff/0", out_q, out_r, out_exc); end
    accept();
    push(16'h8000, 16'hFFFF, 4'd2, 1'b1);
    wait_valid(100, got);
    total++; if (!got || out_q !== 16'h8000 || out_r !== 16'h0000 || out_exc !== 1'b0) begin bad++; $display("FAIL sgn_ovf got=%0h/%0h/%0b exp=8000/0/0", out_q, out_r, out_exc); end
    accept();
    push(16'hFFF9, 16'd0, 4'd3, 1'b1);
    wait_valid(100, got);
    total++; if (!got || out_q !== 16'hFFFF || out_r !== 16'hFFF9 || out_exc !== 1'b1) begin bad++; $display("FAIL sgn_dz got=%0h/%0h/%0b exp=ffff/fff9/1", out_q, out_r, out_exc); end
    accept();
`else
    push(16'hFFF9, 16'd2, 4'd1, 1'b1);
    wait_valid(100, got);
    total++; if (!got || out_q !== 16'h7FFC || out_r !== 16'h0001) begin bad++; $display("FAIL uns_sgn_ignored got=%0h/%0h exp=7ffc/1", out_q, out_r); end
    accept();
    push(16'h8000, 16'hFFFF, 4'd2, 1'b1);
    wait_valid(100, got);
    total++; if (!got || out_q !== 16'h0000 || out_r !== 16'h8000 || out_exc !== 1'b0) begin bad++; $display("FAIL uns_big_div got=%0h/%0h/%0b exp=0/8000/0", out_q, out_r, out_exc); end
    accept();
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    int r0;
    auto_div = 1'b0;
    r0 = req_cnt;
    push(16'd10, 16'd2, 4'd6, 1'b0);
    push(16'd11, 16'd2, 4'd7, 1'b0);
    push(16'd12, 16'd2, 4'd8, 1'b0);
    repeat (2) @(negedge clk);
    total++; if (req_cnt - r0 != 1 || busy !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%0d/%0b exp=1/1", req_cnt - r0, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_state got=%0b/%0b exp=0/0", busy, out_valid); end
    total++; if (in_ready !== 1'b1 || div_req !== 1'b0) begin bad++; $display("FAIL rst_mid_ports got=%0b/%0b exp=1/0", in_ready, div_req); end
    manual_q = 16'd5; manual_r = 16'd0; manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || div_req || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_late_ready got=%0b exp=0", seen); end
  endtask

  task automatic test_idle_ready();
    bit got;
    bit seen;
    auto_div = 1'b0;
    manual_q = 16'hABCD; manual_r = 16'h1111; manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL idle_ready_effect got=%0b exp=0", seen); end
    auto_div = 1'b1; div_lat = 1;
    push(16'd9, 16'd4, 4'hA, 1'b0);
    wait_valid(100, got);
    total++; if (!got || out_q !== 16'd2 || out_r !== 16'd1 || out_tag !== 4'hA) begin bad++; $display("FAIL idle_followup got=%0d/%0d/%0d exp=2/1/10", out_q, out_r, out_tag); end
    accept();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_back_to_back();
    test_signed();
    test_reset_mid();
    test_idle_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_dispatch.md
# div_dispatch

Operand buffer and issue controller sitting directly upstream of the iterative divider. It queues divide requests from the execute stage, issues them one at a time to the divider over its `req`/`ready` handshake, and captures each result. Every result returns with its request tag on a valid/ready output port. It also normalises divide-by-zero results and, optionally, handles signed operands around the unsigned divider.

## Interface
- `N`, 16, operand/result width (matches divider)
- `DEPTH`, 4, request FIFO entries, power of two, ≥2
- `TAG_W`, 4, request tag width
- `clk` in 1, clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `in_valid` in 1, request present
- `in_ready` out 1, FIFO not full
- `in_dividend` in N, dividend
- `in_divisor` in N, divisor
- `in_tag` in TAG_W, request tag
- `in_signed` in 1, signed request (ignored unless `DIV_SIGNED_EN`)
- `div_req` out 1, one-cycle issue pulse to divider
- `div_dividend` out N, operand to divider
- `div_divisor` out N, operand to divider
- `div_ready` in 1, divider completion pulse
- `div_q` in N, divider quotient
- `div_r` in N, divider remainder
- `div_exc` in 1, divider divide-by-zero flag
- `out_valid` out 1, result present
- `out_ready` in 1, consumer accepts
- `out_q` out N, final quotient
- `out_r` out N, final remainder
- `out_tag` out TAG_W, tag of result
- `out_exc` out 1, divide-by-zero occurred
- `busy` out 1, FIFO non-empty or FSM not IDLE

## Operation
- Push when `in_valid && in_ready`; `in_ready = (count != DEPTH)`. A full FIFO blocks a push even if a pop occurs the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: FIFO non-empty → ISSUE. Head entry is popped into the in-flight register.
  - ISSUE: `div_req`=1 for exactly this cycle, with the in-flight operands → WAIT.
  - WAIT: on `div_ready`, capture `div_q`/`div_r`/`div_exc` into the result register → RESP. No timeout.
  - RESP: `out_valid`=1 with stable outputs until `out_ready`, then → IDLE.
- `div_ready` outside WAIT is ignored.
- `div_exc`=1: `out_exc`=1, `out_q`=all ones, `out_r`=original dividend. `div_q`/`div_r` are discarded.
- Results leave in request order; only one request is in flight.
- Reset (any state, including mid-divide): FIFO emptied, FSM→IDLE. All outputs 0 except `in_ready`=1. The divider is reset by the same event.

## Timing
- All outputs registered except `in_ready` (combinational from `count`).
- Push into an empty FIFO at cycle t: IDLE sees it at t+1, `div_req` high at t+2.
- `div_ready` at cycle w → `out_valid` from w+1.
- Back-to-back requests: result handshake at cycle h → next `div_req` no earlier than h+2.
- `div_dividend`/`div_divisor` hold their values from ISSUE until leaving WAIT.

## Configuration
- `DIV_SIGNED_EN` defined: when `in_signed`=1, two's-complement magnitudes are sent to the divider.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Overflow case -2^(N-1) / -1 yields `out_q`=0x8000 (N=16), `out_r`=0, `out_exc`=0.
  - Divide-by-zero follows the rule above.
- Undefined: `in_signed` ignored, all operations unsigned, sign logic absent.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, ISSUE, WAIT, RESP}
  - packed struct `div_entry_t` {dividend, divisor, tag, signed}
  - result struct `div_result_t`
- Sub-module `div_fifo`: synchronous FIFO of `div_entry_t`, DEPTH entries, pointer-plus-count, async active-high reset.

## Test plan
- Unsigned 100/7, tag 3 → `out_q`=14, `out_r`=2, `out_tag`=3, `out_exc`=0; `div_req` high exactly one cycle.
- 50/0 → `out_q`=0xFFFF, `out_r`=50, `out_exc`=1.
- Push 5 requests with tags 0–4 while `div_ready` is delayed → `in_ready` drops after 4. Results come back in order 0–4, and `out_valid` holds while `out_ready`=0.
- Signed -7/2 with `DIV_SIGNED_EN` → `out_q`=0xFFFD, `out_r`=0xFFFF. Signed 0x8000/0xFFFF → `out_q`=0x8000, `out_r`=0, `out_exc`=0.
- `rst` pulsed during WAIT with 2 queued → `busy`=0, `out_valid`=0, `in_ready`=1. A late `div_ready` after reset is ignored.
- `div_ready` asserted while in IDLE → no state change, no `out_valid`.
